// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit and its result buffer.
package gcd_pkg;

  // Operand and result width used throughout the GCD block.
  localparam int GCD_WL = 8;

  typedef logic [GCD_WL-1:0] gcd_word_t;

endpackage : gcd_pkg

// File: rtl/gcd_fifo_mem.sv
// Storage array for the GCD result FIFO: one synchronous write port and
// one asynchronous read port. The contents are deliberately not reset.
module gcd_fifo_mem #(
  parameter int WL    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WL-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WL-1:0] rdata
);

  logic [WL-1:0] mem_q [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : gcd_fifo_mem

// File: rtl/gcd_res_fifo.sv
// Result buffer downstream of the GCD unit. Captures each result on the
// in_val/in_rdy handshake and presents it on out_val/out_rdy, with an
// occupancy count and a high-water mark for bring-up and debug.
// There is no bypass path: every output comes from register state.
module gcd_res_fifo
  import gcd_pkg::*;
#(
  parameter int WL    = GCD_WL,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] in_data,
  input  logic          in_val,
  output logic          in_rdy,
  output logic [WL-1:0] out_data,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [CW-1:0] count,
  output logic [CW-1:0] max_count
);

  localparam int AW = CW - 1;

  // Pointers carry one extra wrap bit above the index bits.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] max_q, max_d;
  logic [CW-1:0] count_next_s;
  logic          full_s, empty_s;
  logic          enq_s, deq_s;
  logic [WL-1:0] rdata_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // in_rdy is a function of registered state only, so a dequeue while full
  // cannot free space for an enqueue in the same cycle.
  assign enq_s = in_val && !full_s && !rst;
  assign deq_s = out_rdy && !empty_s && !rst;

  gcd_fifo_mem #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (enq_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata_s)
  );

  // Next-state pointers and high-water mark.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    max_d        = max_q;
    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_next_s = wr_ptr_d - rd_ptr_d;
    // Occupancy never exceeds DEPTH, so the mark saturates there naturally.
    if (count_next_s > max_q) begin
      max_d = count_next_s;
    end else begin
      max_d = max_q;
    end
  end

  // Pointer and high-water registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {CW{1'b0}};
      rd_ptr_q <= {CW{1'b0}};
      max_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      max_q    <= max_d;
    end
  end

  assign in_rdy    = !full_s;
  assign out_val   = !empty_s;
  assign out_data  = empty_s ? {WL{1'b0}} : rdata_s;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign max_count = max_q;

endmodule : gcd_res_fifo
